// File: rtl/password_pkg.sv
// Shared types and default sizing for the password-entry sequencer.
package password_pkg;

  localparam int DEF_DIGITS      = 4;
  localparam int DEF_DIGIT_W     = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_PASS,
    ST_FAIL,
    ST_LOCK
  } pw_state_t;

endpackage

// File: rtl/password_sequencer_if.sv
// Keypad/password bus and lights-controller drive signals of the sequencer.
interface password_sequencer_if
  import password_pkg::*;
#(
  parameter int DIGITS    = DEF_DIGITS,
  parameter int DIGIT_W   = DEF_DIGIT_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES
);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  logic [DIGIT_W-1:0]        digit;
  logic                      digitValid;
  logic                      clear;
  logic                      pwLoad;
  logic [DIGITS*DIGIT_W-1:0] pwValue;
  logic                      trueOut;
  logic                      falseOut;
  logic                      enableOut;
  logic                      lightsRstN;
  logic                      locked;
  logic [TRIES_W-1:0]        triesLeft;

  modport master (
    output digit, digitValid, clear, pwLoad, pwValue,
    input  trueOut, falseOut, enableOut, lightsRstN, locked, triesLeft
  );

  modport slave (
    input  digit, digitValid, clear, pwLoad, pwValue,
    output trueOut, falseOut, enableOut, lightsRstN, locked, triesLeft
  );

endinterface

// File: rtl/password_sequencer_code_capture.sv
// Digit shift register and counter; the first digit entered ends up in the MSBs.
module code_capture
  import password_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int CNT_W   = $clog2(DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      shift,
  input  logic [DIGIT_W-1:0]        digit,
  input  logic [DIGITS*DIGIT_W-1:0] ref_code,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      eq
);
  localparam int CODE_W = DIGITS * DIGIT_W;

  logic [CODE_W-1:0] code;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      code  <= '0;
      count <= '0;
    end else if (shift) begin
      code  <= (code << DIGIT_W) | CODE_W'(digit);
      count <= count + CNT_W'(1);
    end
  end

  assign full = (count == CNT_W'(DIGITS));
  assign eq   = (code == ref_code);

endmodule

// File: rtl/password_sequencer.sv
// Password-entry FSM: collects digits, checks the code, counts failures and
// applies a timed lockout while driving the downstream lights controller.
module password_sequencer
  import password_pkg::*;
#(
  parameter int DIGITS      = DEF_DIGITS,
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  password_sequencer_if.slave bus
);
  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam int CNT_W   = $clog2(DIGITS + 1);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  pw_state_t          state, next_state;
  logic [CODE_W-1:0]  pw_reg;
  logic [TRIES_W-1:0] tries;
  logic [LOCK_W-1:0]  lock_cnt;

  logic [CNT_W-1:0]   cap_count;
  logic               cap_full, cap_eq, cap_shift, cap_clr;

  logic true_q, false_q, enable_q, lrn_q, locked_q;
  logic true_d, false_d, enable_d, lrn_d, locked_d;

  code_capture #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .CNT_W   (CNT_W)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .clr      (cap_clr),
    .shift    (cap_shift),
    .digit    (bus.digit),
    .ref_code (pw_reg),
    .count    (cap_count),
    .full     (cap_full),
    .eq       (cap_eq)
  );

  // pwLoad wins over a digit in IDLE; clear wins over a digit in ENTRY.
  assign cap_shift = bus.digitValid &&
                     (((state == ST_IDLE) && !bus.pwLoad) ||
                      ((state == ST_ENTRY) && !bus.clear));
  assign cap_clr   = (next_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (cap_shift) next_state = (DIGITS == 1) ? ST_CHECK : ST_ENTRY;
      ST_ENTRY: begin
        if (bus.clear)
          next_state = ST_IDLE;
        else if (cap_shift && (cap_count == CNT_W'(DIGITS - 1)))
          next_state = ST_CHECK;
      end
      ST_CHECK: next_state = (cap_full && cap_eq) ? ST_PASS : ST_FAIL;
      ST_PASS:  if (bus.clear) next_state = ST_IDLE;
      ST_FAIL:  next_state = (tries == '0) ? ST_LOCK : ST_IDLE;
      ST_LOCK:  if (lock_cnt == '0) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pw_reg   <= '0;
      tries    <= TRIES_W'(MAX_TRIES);
      lock_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && bus.pwLoad)
        pw_reg <= bus.pwValue;

      if (state == ST_CHECK) begin
        if (cap_full && cap_eq) tries <= TRIES_W'(MAX_TRIES);
        else if (tries != '0)   tries <= tries - TRIES_W'(1);
      end else if ((state == ST_LOCK) && (lock_cnt == '0)) begin
        tries <= TRIES_W'(MAX_TRIES);
      end

      if ((state == ST_FAIL) && (tries == '0))
        lock_cnt <= LOCK_W'(LOCK_CYCLES - 1);
      else if ((state == ST_LOCK) && (lock_cnt != '0))
        lock_cnt <= lock_cnt - LOCK_W'(1);
    end
  end

  // Lights drive lags the state by one cycle so PASS/FAIL appear two edges
  // after the last digit; clear and the FAIL pulse act on the same edge.
  always_comb begin
    true_d   = (state == ST_PASS) && !bus.clear;
    enable_d = (next_state == ST_ENTRY) || (next_state == ST_CHECK) ||
               (state == ST_CHECK);
    false_d  = !true_d && !enable_d;
    lrn_d    = !((state == ST_FAIL) ||
                 (((state == ST_ENTRY) || (state == ST_PASS)) && bus.clear));
    locked_d = (next_state == ST_LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      true_q   <= 1'b0;
      false_q  <= 1'b1;
      enable_q <= 1'b0;
      lrn_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      true_q   <= true_d;
      false_q  <= false_d;
      enable_q <= enable_d;
      lrn_q    <= lrn_d;
      locked_q <= locked_d;
    end
  end

  assign bus.trueOut    = true_q;
  assign bus.falseOut   = false_q;
  assign bus.enableOut  = enable_q;
  assign bus.lightsRstN = lrn_q;
  assign bus.locked     = locked_q;
  assign bus.triesLeft  = tries;

endmodule

// File: tb/tb_password_sequencer.sv
// Directed bench for password_sequencer with hand-computed expectations.
module tb_password_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  password_sequencer_if #(.DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

  password_sequencer #(
    .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCK_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      bus.digit      = code[15-4*i -: 4];
      bus.digitValid = 1'b1;
      tick();
    end
    bus.digitValid = 1'b0;
  endtask

  // Wrong code: N+1 CHECK, N+2 FAIL drive visible, N+3 back to IDLE/LOCK.
  task automatic wrong_attempt(input logic [15:0] code);
    enter_code(code);
    tick();
    tick();
    tick();
  endtask

  task automatic pass_and_clear(input string tag, input logic [15:0] code);
    enter_code(code);
    tick();
    tick();
    chk({tag, "_true"}, bus.trueOut, 1'b1);
    chk({tag, "_tries"}, bus.triesLeft, 2'd3);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_true"}, bus.trueOut, 1'b0);
    chk({tag, "_false"}, bus.falseOut, 1'b1);
    chk({tag, "_en"}, bus.enableOut, 1'b0);
    chk({tag, "_lrn"}, bus.lightsRstN, 1'b0);
    chk({tag, "_locked"}, bus.locked, 1'b0);
    chk({tag, "_tries"}, bus.triesLeft, 2'd3);
  endtask

  initial begin
    int lock_len;
    bit en_seen;

    bus.digit = '0; bus.digitValid = 1'b0; bus.clear = 1'b0;
    bus.pwLoad = 1'b0; bus.pwValue = '0;

    // 1: reset, load 1234, correct entry
    tick();
    rst = 1'b0;
    check_reset_vals("rst");
    tick();
    chk("rst_lrn_after", bus.lightsRstN, 1'b1);
    bus.pwLoad = 1'b1; bus.pwValue = 16'h1234;
    tick();
    bus.pwLoad = 1'b0;
    enter_code(16'h1234);
    chk("t1_en_entry", bus.enableOut, 1'b1);
    chk("t1_false_entry", bus.falseOut, 1'b0);
    tick();
    chk("t1_true_n1", bus.trueOut, 1'b0);
    tick();
    chk("t1_true_n2", bus.trueOut, 1'b1);
    chk("t1_false_n2", bus.falseOut, 1'b0);
    chk("t1_en_n2", bus.enableOut, 1'b0);
    chk("t1_tries", bus.triesLeft, 2'd3);
    tick();
    chk("t1_hold", bus.trueOut, 1'b1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t1_clr_lrn", bus.lightsRstN, 1'b0);
    chk("t1_clr_true", bus.trueOut, 1'b0);
    chk("t1_clr_false", bus.falseOut, 1'b1);
    tick();
    chk("t1_lrn_back", bus.lightsRstN, 1'b1);

    // 2: wrong code
    enter_code(16'h1235);
    tick();
    chk("t2_lrn_n1", bus.lightsRstN, 1'b1);
    tick();
    chk("t2_lrn_pulse", bus.lightsRstN, 1'b0);
    chk("t2_tries", bus.triesLeft, 2'd2);
    chk("t2_true", bus.trueOut, 1'b0);
    chk("t2_false", bus.falseOut, 1'b1);
    tick();
    chk("t2_lrn_end", bus.lightsRstN, 1'b1);
    chk("t2_locked", bus.locked, 1'b0);
    pass_and_clear("t2_restore", 16'h1234);

    // 3: three wrong codes -> lockout of 16 cycles
    wrong_attempt(16'h9999);
    chk("t3_tries_a", bus.triesLeft, 2'd2);
    wrong_attempt(16'h8888);
    chk("t3_tries_b", bus.triesLeft, 2'd1);
    enter_code(16'h7777);
    tick();
    tick();
    chk("t3_locked_start", bus.locked, 1'b1);
    chk("t3_tries_zero", bus.triesLeft, 2'd0);
    lock_len = 1;
    en_seen = 1'b0;
    bus.digitValid = 1'b1; bus.digit = 4'h1;
    bus.pwLoad = 1'b1; bus.pwValue = 16'hABCD;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.enableOut) en_seen = 1'b1;
      if (!bus.locked) break;
      lock_len++;
    end
    bus.digitValid = 1'b0; bus.pwLoad = 1'b0;
    chk("t3_lock_len", lock_len, 16);
    chk("t3_lock_ignored", en_seen, 1'b0);
    chk("t3_tries_reload", bus.triesLeft, 2'd3);
    pass_and_clear("t3_after", 16'h1234);

    // 4: clear with digitValid mid-entry
    bus.digitValid = 1'b1;
    bus.digit = 4'h1; tick();
    bus.digit = 4'h2; tick();
    bus.digit = 4'h3; bus.clear = 1'b1; tick();
    bus.digitValid = 1'b0; bus.clear = 1'b0;
    chk("t4_en", bus.enableOut, 1'b0);
    chk("t4_lrn", bus.lightsRstN, 1'b0);
    tick();
    chk("t4_idle", bus.enableOut, 1'b0);
    pass_and_clear("t4_pass", 16'h1234);

    // 5: pwLoad + digitValid in IDLE; pwLoad in ENTRY ignored
    bus.pwLoad = 1'b1; bus.pwValue = 16'hABCD;
    bus.digitValid = 1'b1; bus.digit = 4'h1;
    tick();
    bus.pwLoad = 1'b0; bus.digitValid = 1'b0;
    chk("t5_dropped", bus.enableOut, 1'b0);
    tick();
    bus.digitValid = 1'b1;
    bus.digit = 4'hA; tick();
    bus.digit = 4'hB; bus.pwLoad = 1'b1; bus.pwValue = 16'h1234; tick();
    bus.pwLoad = 1'b0;
    bus.digit = 4'hC; tick();
    bus.digit = 4'hD; tick();
    bus.digitValid = 1'b0;
    tick();
    tick();
    chk("t5_pass", bus.trueOut, 1'b1);
    bus.clear = 1'b1; tick(); bus.clear = 1'b0; tick();
    wrong_attempt(16'h1234);
    chk("t5_old_rejected", bus.triesLeft, 2'd2);

    // 6: reset mid-entry, then mid-lock
    bus.digitValid = 1'b1;
    bus.digit = 4'hA; tick();
    bus.digit = 4'hB; rst = 1'b1; tick();
    rst = 1'b0; bus.digitValid = 1'b0;
    check_reset_vals("t6_entry");
    tick();
    wrong_attempt(16'h1111);
    wrong_attempt(16'h1111);
    wrong_attempt(16'h1111);
    tick();
    tick();
    chk("t6_in_lock", bus.locked, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_vals("t6_lock");
    tick();
    pass_and_clear("t6_pw_zero", 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
